wb_unit: RTL
============

# wb_unit

Parametrised register-file / HI / LO writeback unit for the dynamic-pipeline MIPS CPU. It sits at the end of the pipeline and picks the register-file write data from NUM_SRC result sources (ALU, MULT, HI, LO, CP0, DMEM, CLZ, …). It also accepts out-of-order late results from multi-cycle units (mult/div) through a valid/ready port backed by a DEPTH-entry FIFO. A single registered write port is arbitrated between the two, and the unit reports pending-write hazards back to ID.

## Interface
Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 5, register-file address width
- NUM_SRC, 8, number of pipeline result sources
- SEL_W, 3, source-select width (≥ clog2(NUM_SRC))
- DEPTH, 4, late-result FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- p_valid  in  1  pipeline instruction present in WB
- p_sel  in  SEL_W  rf write source select
- p_src  in  NUM_SRC*DATA_W  sources, source i at [i*DATA_W +: DATA_W]
- p_addr  in  ADDR_W  rf write address
- p_rf_we, p_hi_we, p_lo_we  in  1 each  pipeline write enables
- p_hi_data, p_lo_data  in  DATA_W each  HI/LO write data
- l_valid  in  1  late result offered
- l_ready  out  1  late result accepted this cycle
- l_addr  in  ADDR_W  late rf address
- l_rf_we, l_hi_we, l_lo_we  in  1 each  late write enables (rf data = l_lo)
- l_hi, l_lo  in  DATA_W each  late result halves
- q_addr_a, q_addr_b  in  ADDR_W  ID-stage source addresses
- q_hit_a, q_hit_b  out  1  queried address has a pending late rf write
- rf_we, hi_we, lo_we  out  1 each  registered write enables
- rf_waddr  out  ADDR_W  registered rf address
- rf_wdata, hi_wdata, lo_wdata  out  DATA_W each  registered write data
- fifo_count  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Pipeline slot is busy when p_valid & (p_rf_we | p_hi_we | p_lo_we). The pipeline always wins, and is never stalled by this unit.
- Late path when slot is free:
  - FIFO non-empty: pop head and write it.
  - FIFO empty and l_valid: bypass l_* directly to the write registers, with no enqueue.
- Enqueue: l_valid & l_ready and the entry is not bypassed. l_ready = (fifo_count < DEPTH) | pop this cycle.
- Simultaneous push and pop: count unchanged. FIFO order is strict; pointers wrap modulo DEPTH.
- Source select: rf data = p_src[p_sel]. If p_sel ≥ NUM_SRC, rf data = 0.
- Address 0: rf_we is forced 0 for any write to address 0 (pipeline or late). HI/LO enables still apply.
- Hazard check: q_hit_x = 1 if any valid FIFO entry with l_rf_we = 1 matches q_addr_x (x ≠ 0), or the l_* beat being accepted this cycle matches. This logic is combinational.
- Idle cycle (slot free and no late data): all write enables registered 0. Data registers hold their previous values.

## Timing
- Latency is 1 cycle: the winner's enables and data appear on rf_*/hi_*/lo_* after the next rising edge. A FIFO entry written at edge N is poppable at edge N+1.
- Maximum late-result latency is DEPTH+1 cycles of free slots after acceptance.
- Reset (async assert, sync-safe release):
  - Every output register is 0, FIFO is emptied, and fifo_count = 0.
  - l_ready = 1 and q_hit_* = 0 immediately.
  - Reset mid-operation discards all queued entries. No write occurs from them after release.
- FIFO full with no pop: l_ready = 0. The producer holds l_* stable until accepted.
- Full with a pop in the same cycle: l_ready = 1 and count stays DEPTH.

## Test plan
- Source select: p_valid=1, p_rf_we=1, p_addr=8, p_sel=5, src5=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0xDEADBEEF. Repeat with p_sel=0…7 and with out-of-range sel on NUM_SRC=6 -> rf_wdata=0.
- $0 guard: pipeline write and late write to address 0 -> rf_we=0. Late write with l_hi_we=1, l_hi=0x1234 -> hi_we=1, hi_wdata=0x1234.
- Bypass vs priority:
  - Idle pipeline, l_valid with l_addr=3, l_lo=0x55 -> rf write 3←0x55 next cycle, fifo_count=0.
  - Same beat while the pipeline writes reg 4 -> reg 4 first, entry queued, reg 3 written on the next free cycle.
- FIFO full/wrap, DEPTH=4:
  - Keep the slot busy and offer 5 late beats -> l_ready drops after 4, fifo_count=4.
  - Free the slot -> entries drain in order, 1 per cycle. The 5th beat is accepted on the first pop cycle. Run 3 fill/drain rounds to check pointer wrap.
- Hazard: queue a late write to reg 9 and set q_addr_a=9, q_addr_b=10 -> q_hit_a=1, q_hit_b=0. After drain -> q_hit_a=0.
- Reset mid-operation: assert rst_n=0 with 3 entries queued -> outputs 0 without waiting for a clock edge, l_ready=1. After release, no rf_we pulses occur for the flushed entries.

Source files
------------

// File: rtl/wb_unit.sv
// wb_unit: writeback stage for the register file and HI/LO.
// The pipeline result always takes the single registered write port when it
// has something to write. Late results from multi-cycle units use the port
// on free cycles. A late beat goes straight to the port when the FIFO is
// empty, and waits in the FIFO otherwise. Pending late rf writes are reported
// to ID as hazards.
module wb_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 3,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      p_valid,
  input  logic [SEL_W-1:0]          p_sel,
  input  logic [NUM_SRC*DATA_W-1:0] p_src,
  input  logic [ADDR_W-1:0]         p_addr,
  input  logic                      p_rf_we,
  input  logic                      p_hi_we,
  input  logic                      p_lo_we,
  input  logic [DATA_W-1:0]         p_hi_data,
  input  logic [DATA_W-1:0]         p_lo_data,
  input  logic                      l_valid,
  output logic                      l_ready,
  input  logic [ADDR_W-1:0]         l_addr,
  input  logic                      l_rf_we,
  input  logic                      l_hi_we,
  input  logic                      l_lo_we,
  input  logic [DATA_W-1:0]         l_hi,
  input  logic [DATA_W-1:0]         l_lo,
  input  logic [ADDR_W-1:0]         q_addr_a,
  input  logic [ADDR_W-1:0]         q_addr_b,
  output logic                      q_hit_a,
  output logic                      q_hit_b,
  output logic                      rf_we,
  output logic                      hi_we,
  output logic                      lo_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [DATA_W-1:0]         hi_wdata,
  output logic [DATA_W-1:0]         lo_wdata,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Split the flat source bus into one word per source.
  logic [DATA_W-1:0] src_arr [NUM_SRC];
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_arr[gi] = p_src[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Pick the pipeline rf data. A select value with no matching source gives 0.
  logic [DATA_W-1:0] sel_data;
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (p_sel == SEL_W'(i)) sel_data = src_arr[i];
    end
  end

  // FIFO storage. Every entry stays visible to the hazard compare.
  logic [ADDR_W-1:0] ent_addr  [DEPTH];
  logic              ent_rf_we [DEPTH];
  logic              ent_hi_we [DEPTH];
  logic              ent_lo_we [DEPTH];
  logic [DATA_W-1:0] ent_hi    [DEPTH];
  logic [DATA_W-1:0] ent_lo    [DEPTH];
  logic [DEPTH-1:0]  ent_valid_reg;
  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W:0]    count_reg;

  logic slot_busy, fifo_empty, pop, bypass, push, accept_rf;
  assign slot_busy  = p_valid & (p_rf_we | p_hi_we | p_lo_we);
  assign fifo_empty = (count_reg == '0);
  assign pop        = ~slot_busy & ~fifo_empty;
  assign bypass     = ~slot_busy & fifo_empty & l_valid;
  assign l_ready    = (count_reg < (PTR_W+1)'(DEPTH)) | pop;
  assign push       = l_valid & l_ready & ~bypass;
  assign accept_rf  = l_valid & l_ready & l_rf_we;
  assign fifo_count = count_reg;

  // Compare each queued entry against both ID query addresses.
  logic [DEPTH-1:0] hit_a_vec, hit_b_vec;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit_a_vec[gi] = ent_valid_reg[gi] & ent_rf_we[gi] & (ent_addr[gi] == q_addr_a);
      assign hit_b_vec[gi] = ent_valid_reg[gi] & ent_rf_we[gi] & (ent_addr[gi] == q_addr_b);
    end
  endgenerate

  // The rst_n term keeps the hazard flags low while reset is asserted, even
  // if a late beat is offered during that time.
  assign q_hit_a = rst_n & (q_addr_a != '0) &
                   ((|hit_a_vec) | (accept_rf & (l_addr == q_addr_a)));
  assign q_hit_b = rst_n & (q_addr_b != '0) &
                   ((|hit_b_vec) | (accept_rf & (l_addr == q_addr_b)));

  // Select the winner of the write port: pipeline, then FIFO head, then bypass.
  logic              w_any, w_rf_we, w_hi_we, w_lo_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_rf_data, w_hi_data, w_lo_data;
  always_comb begin
    w_any     = 1'b0;
    w_rf_we   = 1'b0;
    w_hi_we   = 1'b0;
    w_lo_we   = 1'b0;
    w_addr    = '0;
    w_rf_data = '0;
    w_hi_data = '0;
    w_lo_data = '0;
    if (slot_busy) begin
      w_any     = 1'b1;
      w_rf_we   = p_rf_we;
      w_hi_we   = p_hi_we;
      w_lo_we   = p_lo_we;
      w_addr    = p_addr;
      w_rf_data = sel_data;
      w_hi_data = p_hi_data;
      w_lo_data = p_lo_data;
    end else if (pop) begin
      w_any     = 1'b1;
      w_rf_we   = ent_rf_we[rd_ptr_reg];
      w_hi_we   = ent_hi_we[rd_ptr_reg];
      w_lo_we   = ent_lo_we[rd_ptr_reg];
      w_addr    = ent_addr[rd_ptr_reg];
      w_rf_data = ent_lo[rd_ptr_reg];
      w_hi_data = ent_hi[rd_ptr_reg];
      w_lo_data = ent_lo[rd_ptr_reg];
    end else if (bypass) begin
      w_any     = 1'b1;
      w_rf_we   = l_rf_we;
      w_hi_we   = l_hi_we;
      w_lo_we   = l_lo_we;
      w_addr    = l_addr;
      w_rf_data = l_lo;
      w_hi_data = l_hi;
      w_lo_data = l_lo;
    end
  end

  // Register the winner. Register $0 is never written. Data holds on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      hi_we    <= 1'b0;
      lo_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      hi_wdata <= '0;
      lo_wdata <= '0;
    end else begin
      rf_we <= w_rf_we & (w_addr != '0);
      hi_we <= w_hi_we;
      lo_we <= w_lo_we;
      if (w_any) begin
        rf_waddr <= w_addr;
        rf_wdata <= w_rf_data;
        hi_wdata <= w_hi_data;
        lo_wdata <= w_lo_data;
      end
    end
  end

  // FIFO control: pointers, occupancy and per-entry valid flags.
  // On a full push+pop the same slot is cleared and then set, so push is applied last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      ent_valid_reg <= '0;
    end else begin
      if (pop) begin
        rd_ptr_reg                <= rd_ptr_reg + PTR_W'(1);
        ent_valid_reg[rd_ptr_reg] <= 1'b0;
      end
      if (push) begin
        wr_ptr_reg                <= wr_ptr_reg + PTR_W'(1);
        ent_valid_reg[wr_ptr_reg] <= 1'b1;
      end
      if (push & ~pop)      count_reg <= count_reg + 1'b1;
      else if (pop & ~push) count_reg <= count_reg - 1'b1;
    end
  end

  // FIFO payload write. The valid flags gate every use, so the payload needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr_reg]  <= l_addr;
      ent_rf_we[wr_ptr_reg] <= l_rf_we;
      ent_hi_we[wr_ptr_reg] <= l_hi_we;
      ent_lo_we[wr_ptr_reg] <= l_lo_we;
      ent_hi[wr_ptr_reg]    <= l_hi;
      ent_lo[wr_ptr_reg]    <= l_lo;
    end
  end

endmodule
